// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter sharing one slave port.
// Round-robin grant per burst, with exactly one burst outstanding at a time.
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 10,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [ID_WIDTH-1:0]   s0_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]            s0_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,
    input  logic [1:0]            s0_axi_arburst,
    input  logic [USER_WIDTH-1:0] s0_axi_aruser,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [ID_WIDTH-1:0]   s0_axi_rid,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rlast,
    output logic [USER_WIDTH-1:0] s0_axi_ruser,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,

    input  logic [ID_WIDTH-1:0]   s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]            s1_axi_arlen,
    input  logic [2:0]            s1_axi_arsize,
    input  logic [1:0]            s1_axi_arburst,
    input  logic [USER_WIDTH-1:0] s1_axi_aruser,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [ID_WIDTH-1:0]   s1_axi_rid,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rlast,
    output logic [USER_WIDTH-1:0] s1_axi_ruser,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [USER_WIDTH-1:0] m_axi_aruser,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic [USER_WIDTH-1:0] m_axi_ruser,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  err_len
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    last_grant_q;
    logic                    grant_q;
    logic [7:0]              beat_cnt_q;
    logic [7:0]              beat_cnt_d;
    logic                    err_len_q;
    logic                    arvalid_q;
    logic [ID_WIDTH-1:0]     arid_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [7:0]              arlen_q;
    logic [2:0]              arsize_q;
    logic [1:0]              arburst_q;
    logic [USER_WIDTH-1:0]   aruser_q;

    logic idle_s;
    logic data_s;
    logic win1_s;
    logic ar_hs_s;
    logic r_hs_s;
    logic len_err_s;

    // Outputs are gated by rstn so nothing handshakes while reset is held.
    assign idle_s  = rstn && (state_q == ST_IDLE);
    assign data_s  = rstn && (state_q == ST_DATA);

    // Master 1 wins if alone, or if both request and master 0 was served last.
    assign win1_s  = s1_axi_arvalid && (!s0_axi_arvalid || !last_grant_q);

    assign s0_axi_arready = idle_s && s0_axi_arvalid && !win1_s;
    assign s1_axi_arready = idle_s && win1_s;
    assign ar_hs_s        = s0_axi_arready || s1_axi_arready;

    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_aruser  = aruser_q;
    assign m_axi_arvalid = arvalid_q;

    assign s0_axi_rid    = m_axi_rid;
    assign s0_axi_rdata  = m_axi_rdata;
    assign s0_axi_rresp  = m_axi_rresp;
    assign s0_axi_rlast  = m_axi_rlast;
    assign s0_axi_ruser  = m_axi_ruser;
    assign s1_axi_rid    = m_axi_rid;
    assign s1_axi_rdata  = m_axi_rdata;
    assign s1_axi_rresp  = m_axi_rresp;
    assign s1_axi_rlast  = m_axi_rlast;
    assign s1_axi_ruser  = m_axi_ruser;

    assign s0_axi_rvalid = data_s && !grant_q && m_axi_rvalid;
    assign s1_axi_rvalid = data_s &&  grant_q && m_axi_rvalid;
    assign m_axi_rready  = data_s && (grant_q ? s1_axi_rready : s0_axi_rready);
    assign r_hs_s        = m_axi_rvalid && m_axi_rready;

    assign beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : (beat_cnt_q + 8'd1);
    assign len_err_s  = (m_axi_rlast && (beat_cnt_q != arlen_q)) ||
                        (!m_axi_rlast && (beat_cnt_q == arlen_q));

    assign err_len = err_len_q;

    // Arbitration FSM, AR payload register, beat counter and sticky length error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            beat_cnt_q   <= 8'd0;
            err_len_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= 8'd0;
            arsize_q     <= 3'd0;
            arburst_q    <= 2'd0;
            aruser_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ar_hs_s) begin
                        grant_q    <= win1_s;
                        arid_q     <= win1_s ? s1_axi_arid    : s0_axi_arid;
                        araddr_q   <= win1_s ? s1_axi_araddr  : s0_axi_araddr;
                        arlen_q    <= win1_s ? s1_axi_arlen   : s0_axi_arlen;
                        arsize_q   <= win1_s ? s1_axi_arsize  : s0_axi_arsize;
                        arburst_q  <= win1_s ? s1_axi_arburst : s0_axi_arburst;
                        aruser_q   <= win1_s ? s1_axi_aruser  : s0_axi_aruser;
                        beat_cnt_q <= 8'd0;
                        arvalid_q  <= 1'b1;
                        state_q    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs_s) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (len_err_s) begin
                            err_len_q <= 1'b1;
                        end
                        // Only rlast ends a burst; the counter is diagnostic.
                        if (m_axi_rlast) begin
                            last_grant_q <= grant_q;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
